// File: rtl/nec_bus_pkg.sv
// Shared types for the NEC V-series bus slave: FSM states, byte-enable decode, open-bus value.
package nec_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_REQ,
        RD_DRIVE,
        WR_REQ,
        WR_END
    } nec_bus_state_t;

    localparam logic [15:0] OPEN_BUS = 16'hFFFF;

    // {A0,UBEn}: word, low byte only, high byte only, or no lanes at all.
    function automatic logic [1:0] be_decode(input logic a0, input logic uben);
        logic [1:0] be;
        case ({a0, uben})
            2'b00:   be = 2'b11;
            2'b01:   be = 2'b01;
            2'b10:   be = 2'b10;
            default: be = 2'b00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/nec_sync.sv
// Multi-flop synchroniser for an asynchronous input vector, loaded with RESET_VAL on reset.
module nec_sync #(
    parameter int               STAGES    = 2,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
    // so the chain shifts by exactly one flop per clock regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/nec_bus_ctrl.sv
// NEC V-series bus-cycle slave: turns each CPU read/write/INTA cycle into one req/ack
// transaction on a 16-bit memory port and drives READY and the AD bus back to the CPU.
module nec_bus_ctrl
    import nec_bus_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 255,
    parameter logic [7:0] INTA_VECTOR = 8'h20
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [19:0] nec_ad_in,
    output logic [15:0] nec_ad_out,
    output logic        nec_ad_oe,
    output logic        nec_ad_dir,
    input  logic        nec_astb,
    input  logic        nec_rdn,
    input  logic        nec_wrn,
    input  logic        nec_ion,
    input  logic        nec_uben,
    input  logic        nec_intakn,
    output logic        nec_ready,
    output logic [19:0] mem_addr,
    output logic        mem_io,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        bus_err
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    logic        astb_s, rdn_s, wrn_s, ion_s, uben_s, intakn_s;
    logic [19:0] ad_s;

    nec_sync #(.STAGES(SYNC_STAGES), .WIDTH(1),  .RESET_VAL(1'b0)) u_sync_astb   (.clk_sys, .reset, .d(nec_astb),   .q(astb_s));
    nec_sync #(.STAGES(SYNC_STAGES), .WIDTH(1),  .RESET_VAL(1'b1)) u_sync_rdn    (.clk_sys, .reset, .d(nec_rdn),    .q(rdn_s));
    nec_sync #(.STAGES(SYNC_STAGES), .WIDTH(1),  .RESET_VAL(1'b1)) u_sync_wrn    (.clk_sys, .reset, .d(nec_wrn),    .q(wrn_s));
    nec_sync #(.STAGES(SYNC_STAGES), .WIDTH(1),  .RESET_VAL(1'b1)) u_sync_ion    (.clk_sys, .reset, .d(nec_ion),    .q(ion_s));
    nec_sync #(.STAGES(SYNC_STAGES), .WIDTH(1),  .RESET_VAL(1'b1)) u_sync_uben   (.clk_sys, .reset, .d(nec_uben),   .q(uben_s));
    nec_sync #(.STAGES(SYNC_STAGES), .WIDTH(1),  .RESET_VAL(1'b1)) u_sync_intakn (.clk_sys, .reset, .d(nec_intakn), .q(intakn_s));
    nec_sync #(.STAGES(SYNC_STAGES), .WIDTH(20), .RESET_VAL('0))   u_sync_ad     (.clk_sys, .reset, .d(nec_ad_in),  .q(ad_s));

    // One extra flop on ASTB and AD: the address is taken from the sample where ASTB was still high.
    logic        astb_q;
    logic [19:0] ad_q;
    logic        astb_fall;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            astb_q <= 1'b0;
            ad_q   <= '0;
        end else begin
            astb_q <= astb_s;
            ad_q   <= ad_s;
        end
    end

    assign astb_fall = astb_q & ~astb_s;

    nec_bus_state_t state, state_nxt;
    logic [7:0]     tmo_cnt;
    logic           tmo_active, timeout, skip, rd_done;

    assign tmo_active = (state == ADDR) || (state == RD_REQ) || (state == WR_REQ);
    assign timeout    = tmo_active && (tmo_cnt == TMO_LIMIT);
    assign skip       = (mem_be == 2'b00);
    assign rd_done    = rdn_s & intakn_s;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (astb_fall) state_nxt = ADDR;
            ADDR: begin
                if (timeout)          state_nxt = IDLE;
                else if (!rdn_s)      state_nxt = skip ? RD_DRIVE : RD_REQ;
                else if (!intakn_s)   state_nxt = RD_DRIVE;
                else if (!wrn_s)      state_nxt = skip ? WR_END : WR_REQ;
            end
            RD_REQ:   if (mem_ack || timeout) state_nxt = RD_DRIVE;
            RD_DRIVE: if (rd_done && !nec_ad_oe) state_nxt = IDLE;
            WR_REQ:   if (mem_ack || timeout) state_nxt = WR_END;
            WR_END:   if (wrn_s) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    logic [15:0] ad_out_nxt, wdata_nxt;
    logic [19:0] addr_nxt;
    logic [1:0]  be_nxt;
    logic        oe_nxt, dir_nxt, ready_nxt, io_nxt, rd_nxt, wr_nxt, err_nxt;

    // NOTE: every output gets a hold default first so no path through the case leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        ad_out_nxt = nec_ad_out;
        oe_nxt     = nec_ad_oe;
        dir_nxt    = nec_ad_dir;
        ready_nxt  = nec_ready;
        addr_nxt   = mem_addr;
        io_nxt     = mem_io;
        be_nxt     = mem_be;
        wdata_nxt  = mem_wdata;
        rd_nxt     = mem_rd;
        wr_nxt     = mem_wr;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (astb_fall) begin
                    addr_nxt  = ad_q;
                    io_nxt    = ~ion_s;
                    be_nxt    = be_decode(ad_q[0], uben_s);
                    ready_nxt = 1'b0;
                end
            end
            ADDR: begin
                if (timeout) begin
                    err_nxt   = 1'b1;
                    ready_nxt = 1'b1;
                end else if (!rdn_s) begin
                    if (skip) begin
                        ad_out_nxt = OPEN_BUS;
                        dir_nxt    = 1'b1;
                    end else begin
                        rd_nxt = 1'b1;
                    end
                end else if (!intakn_s) begin
                    ad_out_nxt = {8'h00, INTA_VECTOR};
                    dir_nxt    = 1'b1;
                end else if (!wrn_s) begin
                    wdata_nxt = ad_s[15:0];
                    if (skip) ready_nxt = 1'b1;
                    else      wr_nxt    = 1'b1;
                end
            end
            RD_REQ: begin
                if (timeout) begin
                    err_nxt    = 1'b1;
                    rd_nxt     = 1'b0;
                    ad_out_nxt = OPEN_BUS;
                    dir_nxt    = 1'b1;
                end else if (mem_ack) begin
                    rd_nxt     = 1'b0;
                    ad_out_nxt = mem_rdata;
                    dir_nxt    = 1'b1;
                end
            end
            RD_DRIVE: begin
                // Turn-on: dir, then oe, then READY. Turn-off: oe first, dir one cycle later.
                if (rd_done) begin
                    if (nec_ad_oe) oe_nxt  = 1'b0;
                    else           dir_nxt = 1'b0;
                end else if (!nec_ad_oe) begin
                    oe_nxt = 1'b1;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            WR_REQ: begin
                if (timeout) begin
                    err_nxt   = 1'b1;
                    wr_nxt    = 1'b0;
                    ready_nxt = 1'b1;
                end else if (mem_ack) begin
                    wr_nxt    = 1'b0;
                    ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            nec_ad_out <= '0;
            nec_ad_oe  <= 1'b0;
            nec_ad_dir <= 1'b0;
            nec_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_io     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            nec_ad_out <= ad_out_nxt;
            nec_ad_oe  <= oe_nxt;
            nec_ad_dir <= dir_nxt;
            nec_ready  <= ready_nxt;
            mem_addr   <= addr_nxt;
            mem_io     <= io_nxt;
            mem_be     <= be_nxt;
            mem_wdata  <= wdata_nxt;
            mem_rd     <= rd_nxt;
            mem_wr     <= wr_nxt;
            bus_err    <= err_nxt;
        end
    end

    // Restarts on every state change; saturates so a stuck state cannot wrap back below the limit.
    always_ff @(posedge clk_sys) begin
        if (reset || (state_nxt != state)) begin
            tmo_cnt <= '0;
        end else if (tmo_active && (tmo_cnt != 8'hFF)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_nec_bus_ctrl.sv
// Self-checking bench for nec_bus_ctrl: directed bus cycles plus randomized read/write/INTA traffic.
module tb_nec_bus_ctrl;
    import nec_bus_pkg::*;

    localparam int         TIMEOUT     = 255;
    localparam logic [7:0] INTA_VECTOR = 8'h20;
    localparam int         KIND_RD     = 0;
    localparam int         KIND_WR     = 1;
    localparam int         KIND_INTA   = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [19:0] nec_ad_in;
    logic [15:0] nec_ad_out;
    logic        nec_ad_oe, nec_ad_dir, nec_ready;
    logic        nec_astb, nec_rdn, nec_wrn, nec_ion, nec_uben, nec_intakn;
    logic [19:0] mem_addr;
    logic        mem_io, mem_rd, mem_wr, mem_ack, bus_err;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk_sys = ~clk_sys;

    nec_bus_ctrl #(
        .SYNC_STAGES(2),
        .TIMEOUT    (TIMEOUT),
        .INTA_VECTOR(INTA_VECTOR)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .nec_ad_in (nec_ad_in),
        .nec_ad_out(nec_ad_out),
        .nec_ad_oe (nec_ad_oe),
        .nec_ad_dir(nec_ad_dir),
        .nec_astb  (nec_astb),
        .nec_rdn   (nec_rdn),
        .nec_wrn   (nec_wrn),
        .nec_ion   (nec_ion),
        .nec_uben  (nec_uben),
        .nec_intakn(nec_intakn),
        .nec_ready (nec_ready),
        .mem_addr  (mem_addr),
        .mem_io    (mem_io),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Initial memory contents: a fixed scramble of the word key.
    function automatic logic [15:0] init_word(input int key);
        return key[15:0] ^ 16'hA5A5;
    endfunction

    function automatic int word_key(input logic io_space, input logic [19:0] addr);
        return int'({io_space, addr[19:1]});
    endfunction

    // Memory slave on the req/ack port, with its own storage updated through the DUT's byte enables.
    logic [15:0] mem_store [int];
    bit          ack_en    = 1'b1;
    int          ack_delay = 0;
    logic [1:0]  wr_be_seen;
    logic [19:0] wr_addr_seen;

    initial begin : mem_slave
        int          waited;
        int          key;
        logic [15:0] w;
        waited    = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk_sys);
            if ((mem_rd || mem_wr) && ack_en && !reset) begin
                if (waited >= ack_delay) begin
                    key = word_key(mem_io, mem_addr);
                    w   = mem_store.exists(key) ? mem_store[key] : init_word(key);
                    if (mem_wr) begin
                        if (mem_be[1]) w[15:8] = mem_wdata[15:8];
                        if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
                        mem_store[key] = w;
                        wr_be_seen     = mem_be;
                        wr_addr_seen   = mem_addr;
                    end
                    mem_rdata = w;
                    mem_ack   = 1'b1;
                    @(negedge clk_sys);
                    mem_ack = 1'b0;
                    waited  = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // Passive observers: request counts, bus_err pulses, and the oe-without-dir hazard.
    int   cyc = 0, viol = 0, err_cycles = 0, err_cyc = 0, rd_rise_cyc = 0;
    int   rd_reqs = 0, wr_reqs = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (nec_ad_oe && !nec_ad_dir) viol++;
            if (bus_err) begin
                err_cycles++;
                err_cyc = cyc;
            end
            if (mem_rd && !prev_rd) begin
                rd_reqs++;
                rd_rise_cyc = cyc;
            end
            if (mem_wr && !prev_wr) wr_reqs++;
            prev_rd = mem_rd;
            prev_wr = mem_wr;
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    // CPU-side reference: what each cycle should produce, from the bus rules alone.
    logic [15:0] ref_mem [int];

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic cpu_start(input logic [19:0] addr, input logic io_space, input logic uben,
                             input int kind, input logic [15:0] wdata);
        nec_ad_in = addr;
        nec_ion   = ~io_space;
        nec_uben  = uben;
        nec_astb  = 1'b1;
        idle(2);
        nec_astb = 1'b0;
        idle(4);
        if (kind == KIND_RD) begin
            nec_rdn = 1'b0;
        end else if (kind == KIND_WR) begin
            nec_ad_in = {4'h0, wdata};
            nec_wrn   = 1'b0;
        end else begin
            nec_intakn = 1'b0;
        end
    endtask

    task automatic do_cycle(input string name, input logic [19:0] addr, input logic io_space,
                            input logic uben, input int kind, input logic [15:0] wdata,
                            input bit expect_tmo);
        logic [1:0]  be_exp;
        logic [15:0] word, exp_rd;
        int          key, rd0, wr0, err0, n;
        be_exp = {~uben, ~addr[0]};
        key    = word_key(io_space, addr);
        word   = ref_mem.exists(key) ? ref_mem[key] : init_word(key);
        rd0    = rd_reqs;
        wr0    = wr_reqs;
        err0   = err_cycles;

        cpu_start(addr, io_space, uben, kind, wdata);
        idle(1);
        check({name, ".ready_low"}, 32'(nec_ready), 0);
        n = 0;
        while (!nec_ready && n < 600) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, ".ready_rise"}, 32'(nec_ready), 1);
        check({name, ".mem_addr"}, 32'(mem_addr), 32'(addr));
        check({name, ".mem_io"}, 32'(mem_io), 32'(io_space));
        check({name, ".mem_be"}, 32'(mem_be), 32'(be_exp));

        if (kind == KIND_WR) begin
            check({name, ".wr_dir"}, 32'(nec_ad_dir), 0);
            if (be_exp != 2'b00) check({name, ".wdata"}, 32'(mem_wdata), 32'(wdata));
            if (be_exp != 2'b00 && !expect_tmo) begin
                if (be_exp[1]) word[15:8] = wdata[15:8];
                if (be_exp[0]) word[7:0]  = wdata[7:0];
                ref_mem[key] = word;
                check({name, ".wr_be_seen"}, 32'(wr_be_seen), 32'(be_exp));
                check({name, ".wr_addr_seen"}, 32'(wr_addr_seen), 32'(addr));
            end
        end else begin
            if (kind == KIND_INTA)                   exp_rd = {8'h00, INTA_VECTOR};
            else if (be_exp == 2'b00 || expect_tmo)  exp_rd = 16'hFFFF;
            else                                     exp_rd = word;
            check({name, ".rd_data"}, 32'(nec_ad_out), 32'(exp_rd));
            check({name, ".rd_oe"}, 32'(nec_ad_oe), 1);
            check({name, ".rd_dir"}, 32'(nec_ad_dir), 1);
        end

        idle(3);
        nec_rdn    = 1'b1;
        nec_wrn    = 1'b1;
        nec_intakn = 1'b1;
        n = 0;
        while ((nec_ad_oe || nec_ad_dir) && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, ".released"}, {30'd0, nec_ad_oe, nec_ad_dir}, 0);
        idle(4);
        check({name, ".end_idle"}, 32'(dut.state), 32'(IDLE));
        check({name, ".rd_reqs"}, rd_reqs - rd0, 32'(kind == KIND_RD && be_exp != 2'b00));
        check({name, ".wr_reqs"}, wr_reqs - wr0, 32'(kind == KIND_WR && be_exp != 2'b00));
        check({name, ".bus_err"}, err_cycles - err0, 32'(expect_tmo));
    endtask

    initial begin : stimulus
        logic [19:0] a;
        logic        io_space, uben;
        int          kind, r, n, lat;

        reset      = 1'b1;
        nec_ad_in  = '0;
        nec_astb   = 1'b0;
        nec_rdn    = 1'b1;
        nec_wrn    = 1'b1;
        nec_ion    = 1'b1;
        nec_uben   = 1'b1;
        nec_intakn = 1'b1;
        idle(4);

        check("rst.ad_out", 32'(nec_ad_out), 0);
        check("rst.oe_dir", {30'd0, nec_ad_oe, nec_ad_dir}, 0);
        check("rst.ready", 32'(nec_ready), 0);
        check("rst.req", {30'd0, mem_rd, mem_wr}, 0);
        check("rst.addr", 32'(mem_addr), 0);
        check("rst.be", 32'(mem_be), 0);
        check("rst.bus_err", 32'(bus_err), 0);
        reset = 1'b0;
        idle(3);

        // Word read with a preloaded value and a slow acknowledge.
        mem_store[word_key(1'b0, 20'h12340)] = 16'hBEEF;
        ref_mem[word_key(1'b0, 20'h12340)]   = 16'hBEEF;
        ack_delay = 5;
        do_cycle("word_rd", 20'h12340, 1'b0, 1'b0, KIND_RD, 16'h0, 1'b0);

        // High-byte write, then read the word back to see only the upper lane changed.
        ack_delay = 1;
        do_cycle("byte_wr_hi", 20'h00101, 1'b0, 1'b0, KIND_WR, 16'h5A00, 1'b0);
        do_cycle("readback", 20'h00100, 1'b0, 1'b0, KIND_RD, 16'h0, 1'b0);

        do_cycle("io_rd", 20'h00040, 1'b1, 1'b0, KIND_RD, 16'h0, 1'b0);
        do_cycle("inta", 20'h00000, 1'b0, 1'b0, KIND_INTA, 16'h0, 1'b0);
        do_cycle("no_lane_rd", 20'h00203, 1'b0, 1'b1, KIND_RD, 16'h0, 1'b0);
        do_cycle("no_lane_wr", 20'h00203, 1'b0, 1'b1, KIND_WR, 16'h1234, 1'b0);

        // Memory never answers: one bus_err pulse, open-bus data, cycle still completes.
        ack_en = 1'b0;
        do_cycle("tmo_rd", 20'h00300, 1'b0, 1'b0, KIND_RD, 16'h0, 1'b1);
        lat = err_cyc - rd_rise_cyc;
        check("tmo_rd.latency", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 3), 1);
        do_cycle("tmo_wr", 20'h00302, 1'b0, 1'b0, KIND_WR, 16'hCAFE, 1'b1);
        ack_en = 1'b1;
        do_cycle("after_tmo", 20'h00302, 1'b0, 1'b0, KIND_RD, 16'h0, 1'b0);

        // Reset while the FPGA is driving read data.
        ack_delay = 2;
        cpu_start(20'h0ABC0, 1'b0, 1'b0, KIND_RD, 16'h0);
        n = 0;
        while (!nec_ad_oe && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("rst_mid.pre_oe", 32'(nec_ad_oe), 1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("rst_mid.oe_dir", {30'd0, nec_ad_oe, nec_ad_dir}, 0);
        check("rst_mid.ready", 32'(nec_ready), 0);
        check("rst_mid.mem_rd", 32'(mem_rd), 0);
        check("rst_mid.addr", 32'(mem_addr), 0);
        check("rst_mid.state", 32'(dut.state), 32'(IDLE));
        nec_rdn = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(3);

        // Back-to-back word reads with minimal spacing.
        ack_delay = 0;
        do_cycle("b2b_0", 20'h00400, 1'b0, 1'b0, KIND_RD, 16'h0, 1'b0);
        do_cycle("b2b_1", 20'h00402, 1'b0, 1'b0, KIND_RD, 16'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a        = 20'h00100 + 20'($urandom_range(0, 15));
            io_space = ($urandom_range(0, 3) == 0);
            uben     = 1'($urandom_range(0, 1));
            r        = $urandom_range(0, 19);
            kind     = (r == 0) ? KIND_INTA : (r < 10) ? KIND_RD : KIND_WR;
            ack_delay = $urandom_range(0, 6);
            do_cycle($sformatf("rand%0d", i), a, io_space, uben, kind, 16'($urandom), 1'b0);
        end

        check("oe_without_dir", viol, 0);
        check("bus_err_total", err_cycles, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
